// File: rtl/vsynth_pkg.sv
// vsynth_pkg: shared voice synth types and constants
package vsynth_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} mix_state_t;

    localparam int VOL_SHIFT = 7;

endpackage

// File: rtl/mixer_scale.sv
// mixer_scale: master volume multiply, shift and saturate of the voice sum
module mixer_scale
    import vsynth_pkg::*;
#(
    parameter int ACC_W = 10,
    parameter int OUT_W = 10
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [6:0]       vol,
    output logic [OUT_W-1:0] value,
    output logic             clip
);
    localparam int PW = ACC_W + 8;
    localparam int CW = (PW > OUT_W) ? PW : OUT_W + 1;

    logic [PW-1:0] prod;
    logic [CW-1:0] scaled;

    // vol+1 makes 127 exact unity; compare at a width holding both scaled and the output ceiling
    always_comb begin
        prod   = PW'(acc) * PW'({1'b0, vol} + 8'd1);
        scaled = CW'(prod >> VOL_SHIFT);
        clip   = scaled > CW'({OUT_W{1'b1}});
        value  = clip ? '1 : scaled[OUT_W-1:0];
    end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: sequential per-frame voice summer with master volume and saturation
module voice_mixer
    import vsynth_pkg::*;
#(
    parameter int VOICE_NUM = 4,
    parameter int SAMPLE_W  = 8,
    parameter int OUT_W     = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_rate,
    input  logic [VOICE_NUM*SAMPLE_W-1:0] samples_in,
    input  logic [VOICE_NUM-1:0]          voice_mute,
    input  logic [6:0]                    master_vol,
    output logic [OUT_W-1:0]              sample_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          clip,
    output logic                          overrun
);
    localparam int ACC_W = SAMPLE_W + $clog2(VOICE_NUM);
    localparam int IW    = (VOICE_NUM > 1) ? $clog2(VOICE_NUM) : 1;

    mix_state_t          state;
    logic [SAMPLE_W-1:0] voice_q [VOICE_NUM];
    logic [VOICE_NUM-1:0] mute_q;
    logic [6:0]          vol_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    addend;
    logic [IW-1:0]       idx;
    logic [OUT_W-1:0]    scaled_v;
    logic [OUT_W-1:0]    scaled_q;
    logic                scaled_clip;
    logic                clip_q;

    assign addend = mute_q[idx] ? '0 : ACC_W'(voice_q[idx]);

    mixer_scale #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_scale (
        .acc  (acc),
        .vol  (vol_q),
        .value(scaled_v),
        .clip (scaled_clip)
    );

    // frame FSM: snapshot, accumulate one voice per cycle, scale, publish
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            scaled_q     <= '0;
            clip_q       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            clip         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            overrun      <= sample_rate && busy;
            case (state)
                IDLE: if (sample_rate) begin
                    for (int k = 0; k < VOICE_NUM; k++)
                        voice_q[k] <= samples_in[k*SAMPLE_W +: SAMPLE_W];
                    mute_q <= voice_mute;
                    vol_q  <= master_vol;
                    acc    <= '0;
                    idx    <= '0;
                    busy   <= 1'b1;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                    if (idx == IW'(VOICE_NUM - 1))
                        state <= SCALE;
                end
                SCALE: begin
                    scaled_q <= scaled_v;
                    clip_q   <= scaled_clip;
                    state    <= OUTPUT;
                end
                OUTPUT: begin
                    sample_out   <= scaled_q;
                    clip         <= clip_q;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized frames against an arithmetic mix model, 4- and 8-voice DUTs
module tb_voice_mixer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_rate = 1'b0;
    logic [31:0] samples_in = '0;
    logic [3:0]  voice_mute = '0;
    logic [6:0]  master_vol = '0;
    logic [9:0]  out4, out8;
    logic        valid4, busy4, clip4, ovr4;
    logic        valid8, busy8, clip8, ovr8;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    voice_mixer dut (
        .clk(clk), .rst(rst), .sample_rate(sample_rate),
        .samples_in(samples_in), .voice_mute(voice_mute), .master_vol(master_vol),
        .sample_out(out4), .sample_valid(valid4), .busy(busy4), .clip(clip4), .overrun(ovr4)
    );

    // eight voices: the four-voice pattern duplicated, so its sum is twice the four-voice sum
    voice_mixer #(.VOICE_NUM(8)) dut8 (
        .clk(clk), .rst(rst), .sample_rate(sample_rate),
        .samples_in({samples_in, samples_in}), .voice_mute({voice_mute, voice_mute}),
        .master_vol(master_vol),
        .sample_out(out8), .sample_valid(valid8), .busy(busy8), .clip(clip8), .overrun(ovr8)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scale_ref(input int sum, input int v);
        return (sum * (v + 1)) / 128;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_out4"}, out4, 0);
        check({tag, "_flags4"}, {valid4, busy4, clip4, ovr4}, 0);
        check({tag, "_out8"}, out8, 0);
        check({tag, "_flags8"}, {valid8, busy8, clip8, ovr8}, 0);
    endtask

    // called at a negedge; strobes one frame and watches 14 cycles
    task automatic frame(input logic [31:0] s, input logic [3:0] m, input logic [6:0] v,
                         input int ovr_at, input int rst_at);
        int sum, r4, r8, e4, e8, ec4, ec8;
        int lat4, lat8, g4, g8, gc4, gc8, nv4, nv8, no4, no8;
        sum = 0;
        for (int k = 0; k < 4; k++)
            if (!m[k]) sum += int'(s[k*8 +: 8]);
        r4  = scale_ref(sum, int'(v));
        r8  = scale_ref(2 * sum, int'(v));
        e4  = r4 > 1023 ? 1023 : r4;
        ec4 = r4 > 1023 ? 1 : 0;
        e8  = r8 > 1023 ? 1023 : r8;
        ec8 = r8 > 1023 ? 1 : 0;
        lat4 = -1; lat8 = -1; g4 = 0; g8 = 0; gc4 = 0; gc8 = 0;
        nv4 = 0; nv8 = 0; no4 = 0; no8 = 0;
        samples_in = s; voice_mute = m; master_vol = v; sample_rate = 1'b1;
        @(negedge clk);
        sample_rate = 1'b0;
        samples_in = $urandom; voice_mute = 4'($urandom); master_vol = 7'($urandom);
        for (int c = 1; c <= 14; c++) begin
            if (c == ovr_at) sample_rate = 1'b1;
            if (c == rst_at) rst = 1'b0;
            @(negedge clk);
            sample_rate = 1'b0;
            rst = 1'b1;
            if (valid4) begin nv4++; lat4 = c; g4 = out4; gc4 = clip4; end
            if (valid8) begin nv8++; lat8 = c; g8 = out8; gc8 = clip8; end
            if (ovr4) no4++;
            if (ovr8) no8++;
            if (c == rst_at) check_idle_zero("rst_mid");
            if (c == 1 && rst_at == 0) begin
                check("busy4", busy4, 1);
                check("busy8", busy8, 1);
            end
        end
        if (rst_at != 0) begin
            check("rst_nv4", nv4, 0);
            check("rst_nv8", nv8, 0);
        end else begin
            check("lat4", lat4, 6);
            check("out4", g4, e4);
            check("clip4", gc4, ec4);
            check("nvalid4", nv4, 1);
            check("lat8", lat8, 10);
            check("out8", g8, e8);
            check("clip8", gc8, ec8);
            check("nvalid8", nv8, 1);
            check("novr4", no4, ovr_at != 0 ? 1 : 0);
            check("novr8", no8, ovr_at != 0 ? 1 : 0);
            check("hold4", out4, e4);
            check("hold8", out8, e8);
            check("idle4", busy4, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        frame({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 7'd127, 0, 0);
        frame({4{8'd255}}, 4'b0000, 7'd127, 0, 0);
        frame({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0101, 7'd127, 0, 0);
        frame({4{8'd200}}, 4'b0000, 7'd63, 0, 0);
        frame({4{8'd200}}, 4'b0000, 7'd0, 0, 0);
        frame({8'd7, 8'd99, 8'd140, 8'd3}, 4'b0000, 7'd127, 2, 0);
        frame({8'd50, 8'd60, 8'd70, 8'd80}, 4'b0000, 7'd127, 0, 3);
        frame({8'd1, 8'd2, 8'd3, 8'd250}, 4'b1000, 7'd100, 0, 0);
        for (int i = 0; i < 24; i++)
            frame($urandom, (i % 3 == 0) ? 4'($urandom) : 4'b0000,
                  (i % 4 == 0) ? 7'd0 : (i % 4 == 1) ? 7'd127 : 7'($urandom),
                  (i % 7 == 3) ? 2 + (i % 5) : 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
